// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS controller (FETCH/DECODE/EXEC/MEM/WB); outputs decode from state and inputs in the same cycle.
// Memory stalls hold the FSM until mem_ack or MEM_TIMEOUT. Macro ILLEGAL_TRAP_EN adds a sticky TRAP state.
module multicycle_ctrl_fsm #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       ir_opcode,
  input  logic [5:0]       ir_funct,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src_sel,
  output logic [1:0]       alu_b_sel,
  output logic [3:0]       alu_ctrl,
  output logic             reg_we,
  output logic [1:0]       reg_dst_sel,
  output logic [1:0]       wb_sel,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
`else
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
`endif

  typedef enum logic [2:0] {CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_JAL, CL_JR, CL_BAD} cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_b_sel;
    logic [1:0] reg_dst_sel;
    logic [1:0] wb_sel;
  } dec_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  dec_t             dec_c, dec_q;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic             to_hit, to_fire;

  assign to_hit  = (state == S_FETCH || state == S_MEM) && (wait_cnt == TIMEOUT);
  assign to_fire = to_hit && !mem_ack;

  always_comb begin
    dec_c = '{cls: CL_BAD, alu_ctrl: 4'b0000, alu_b_sel: 2'd0, reg_dst_sel: 2'd0, wb_sel: 2'd0};
    case (ir_opcode)
      6'b000000: begin
        dec_c.reg_dst_sel = 2'd1;
        case (ir_funct)
          6'b100000: begin dec_c.cls = CL_ALU; dec_c.alu_ctrl = 4'b0000; end
          6'b000000: begin dec_c.cls = CL_ALU; dec_c.alu_ctrl = 4'b0100; dec_c.alu_b_sel = 2'd3; end
          6'b100100: begin dec_c.cls = CL_ALU; dec_c.alu_ctrl = 4'b0101; end
          6'b100111: begin dec_c.cls = CL_ALU; dec_c.alu_ctrl = 4'b0111; end
          6'b101010: begin dec_c.cls = CL_ALU; dec_c.alu_ctrl = 4'b1011; end
          6'b001000: begin dec_c.cls = CL_JR;  dec_c.alu_ctrl = 4'b1010; dec_c.reg_dst_sel = 2'd0; end
          default:   dec_c.reg_dst_sel = 2'd0;
        endcase
      end
      6'b001000: begin dec_c.cls = CL_ALU; dec_c.alu_ctrl = 4'b0000; dec_c.alu_b_sel = 2'd1; end
      6'b001100: begin dec_c.cls = CL_ALU; dec_c.alu_ctrl = 4'b0110; dec_c.alu_b_sel = 2'd2; end
      6'b100011: begin dec_c.cls = CL_LW;  dec_c.alu_ctrl = 4'b0010; dec_c.alu_b_sel = 2'd1; dec_c.wb_sel = 2'd1; end
      6'b101011: begin dec_c.cls = CL_SW;  dec_c.alu_ctrl = 4'b0011; dec_c.alu_b_sel = 2'd1; end
      6'b000100: begin dec_c.cls = CL_BEQ; dec_c.alu_ctrl = 4'b1000; end
      6'b000011: begin dec_c.cls = CL_JAL; dec_c.alu_ctrl = 4'b1001; dec_c.reg_dst_sel = 2'd2; dec_c.wb_sel = 2'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      dec_q    <= '0;
      wait_cnt <= '0;
      ret_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        dec_q <= dec_c;
      // Clearing on any state change covers entry to FETCH and MEM; a timeout re-enters FETCH.
      if (state_nxt != state || to_fire)
        wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        wait_cnt <= wait_cnt + 8'd1;
      if (state_nxt == S_FETCH && state != S_FETCH && !to_fire)
        ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ack) state_nxt = S_DECODE;
                else if (to_hit) state_nxt = S_FETCH;
      S_DECODE: begin
        if (dec_c.cls == CL_BAD)
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          state_nxt = S_FETCH;
`endif
        else
          state_nxt = S_EXEC;
      end
      S_EXEC: begin
        case (dec_q.cls)
          CL_ALU:        state_nxt = S_WB;
          CL_LW, CL_SW:  state_nxt = S_MEM;
          default:       state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ack)     state_nxt = (dec_q.cls == CL_SW) ? S_FETCH : S_WB;
        else if (to_hit) state_nxt = S_FETCH;
      end
      S_WB:     state_nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_nxt = S_TRAP;
`endif
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src_sel   = 2'd0;
    alu_b_sel    = 2'd0;
    alu_ctrl     = 4'b0000;
    reg_we       = 1'b0;
    reg_dst_sel  = 2'd0;
    wb_sel       = 2'd0;
    bus_err      = 1'b0;
    illegal      = 1'b0;
    retired      = '0;
    if (!rst) begin
      retired = ret_cnt;
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
        alu_ctrl    = dec_q.alu_ctrl;
        alu_b_sel   = dec_q.alu_b_sel;
        reg_dst_sel = dec_q.reg_dst_sel;
        wb_sel      = dec_q.wb_sel;
      end
      case (state)
        S_FETCH: begin
          mem_req = !to_fire;
          bus_err = to_fire;
          ir_we   = mem_ack;
          pc_we   = mem_ack;
        end
        S_EXEC: begin
          case (dec_q.cls)
            CL_BEQ: begin pc_we = alu_zero; pc_src_sel = 2'd1; end
            CL_JAL: begin reg_we = 1'b1; pc_we = 1'b1; pc_src_sel = 2'd2; end
            CL_JR:  begin pc_we = 1'b1; pc_src_sel = 2'd3; end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req      = !to_fire;
          mem_addr_sel = 1'b1;
          mem_we       = (dec_q.cls == CL_SW) && !to_fire;
          bus_err      = to_fire;
        end
        S_WB:    reg_we = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:  illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
